// File: rtl/fft_pkg.sv
// Shared constants and FSM state encoding for the in-place radix-2 FFT controller.
package fft_pkg;
  localparam int LOG2N      = 8;
  localparam int RD_LAT     = 1;
  localparam int BF_LAT     = 3;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_NEXT,
    ST_FIN
  } state_t;
endpackage

// File: rtl/fft_addr_fifo.sv
// Synchronous FIFO holding issued operand address pairs until their butterfly result returns.
module fft_addr_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wp, rp;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign dout  = mem[rp[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (PW+1)'(1);
      if (pop && !empty) rp <= rp + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !rst) mem[wp[PW-1:0]] <= din;
  end
endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 FFT sequencer: issues butterfly operand reads stage by stage and
// returns write-back addresses as results arrive.
module fft_ctrl #(
  parameter int LOG2N  = fft_pkg::LOG2N,
  parameter int RD_LAT = fft_pkg::RD_LAT,
  parameter int AW     = LOG2N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [LOG2N-1:0]   stage,
  output logic               rd_en,
  output logic [AW-1:0]      rd_addr_a,
  output logic [AW-1:0]      rd_addr_b,
  output logic [LOG2N-2:0]   tw_addr,
  output logic               bf_en,
  input  logic               bf_finish,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr_a,
  output logic [AW-1:0]      wr_addr_b,
  output logic               err
);
  import fft_pkg::*;

  localparam int N     = 1 << LOG2N;
  localparam int HALFN = N / 2;
  localparam int KW    = LOG2N - 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  state_t             state, nxt;
  logic [KW-1:0]      k;
  logic [CW-1:0]      outst;
  logic [RD_LAT:1]    vld_pipe;
  logic               k_last, s_last, pop, fifo_empty, fifo_full;
  logic [2*AW-1:0]    fifo_head;
  logic [AW-1:0]      kx, half, j, base;
  int                 s;

  assign k_last = (k == KW'(HALFN - 1));
  assign s_last = (stage == LOG2N'(LOG2N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (start) nxt = ST_ISSUE;
      ST_ISSUE: if (k_last) nxt = ST_DRAIN;
      // Wait for every result of this stage before the next stage reads them back.
      ST_DRAIN: if (outst == '0) nxt = ST_NEXT;
      ST_NEXT:  nxt = s_last ? ST_FIN : ST_ISSUE;
      ST_FIN:   nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != ST_IDLE);
    rd_en = (state == ST_ISSUE);
    done  = (state == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      stage <= '0;
      outst <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          k     <= '0;
          stage <= '0;
        end
        ST_ISSUE: if (!k_last) k <= k + KW'(1);
        ST_NEXT: if (!s_last) begin
          k     <= '0;
          stage <= stage + LOG2N'(1);
        end
        default: ;
      endcase
      case ({rd_en, pop})
        2'b10:   outst <= outst + CW'(1);
        2'b01:   outst <= outst - CW'(1);
        default: ;
      endcase
      if (bf_finish && (!busy || fifo_empty)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= rd_en;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end
  assign bf_en = vld_pipe[RD_LAT];

  // Butterfly pair addressing: j indexes within a group of size 2*half.
  always_comb begin
    s    = int'(stage);
    kx   = AW'(k);
    half = AW'(1) << s;
    j    = kx & (half - AW'(1));
    base = ((kx >> s) << (s + 1)) | j;
    rd_addr_a = rd_en ? base : '0;
    rd_addr_b = rd_en ? base + half : '0;
    tw_addr   = rd_en ? (KW'(j) << (KW - s)) : '0;
  end

  assign pop       = bf_finish && busy && !fifo_empty;
  assign wr_en     = pop;
  assign wr_addr_a = wr_en ? fifo_head[2*AW-1:AW] : '0;
  assign wr_addr_b = wr_en ? fifo_head[AW-1:0]    : '0;

  fft_addr_fifo #(
    .W     (2*AW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_en),
    .pop   (pop),
    .din   ({rd_addr_a, rd_addr_b}),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Overflow cannot occur with a well-behaved butterfly; keep the flag observable in the netlist.
  logic unused_full;
  assign unused_full = fifo_full;
endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl at N=8: address table, latency, drain, abort and error checks.
module tb_fft_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, bf_finish, inj;
  logic       busy, done, rd_en, bf_en, wr_en, err;
  logic [2:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_addr;
  logic [2:0] bf_sr;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int st;
    int a;
    int b;
    int tw;
  } vec_t;
  vec_t tbl [12];

  fft_ctrl #(.LOG2N(3), .RD_LAT(1), .AW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .bf_en(bf_en), .bf_finish(bf_finish), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b), .err(err)
  );

  always #5 clk = ~clk;

  // Butterfly model: result valid three cycles after bf_en.
  always @(posedge clk) begin
    if (rst) bf_sr <= '0;
    else     bf_sr <= {bf_sr[1:0], bf_en};
  end
  assign bf_finish = bf_sr[2] | inj;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(nm, {busy, done, rd_en, bf_en, wr_en, err, stage, rd_addr_a, rd_addr_b,
             tw_addr, wr_addr_a, wr_addr_b}, 32'd0);
  endtask

  task automatic run_fft(input bit inj_start, input bit abort);
    int rd_i, wr_i, cyc;
    int rd_cyc [12];
    bit fin, prev_rd, injected;
    rd_i = 0; wr_i = 0; cyc = 0; fin = 0; prev_rd = 0; injected = 0;
    start = 1'b1;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (prev_rd || bf_en) chk("bf_en_latency", bf_en, prev_rd);
      prev_rd = rd_en;
      if (rd_en) begin
        if (rd_i >= 12) chk("rd_count_excess", rd_i, 11);
        else begin
          chk("rd_stage", stage, tbl[rd_i].st);
          chk("rd_addr_a", rd_addr_a, tbl[rd_i].a);
          chk("rd_addr_b", rd_addr_b, tbl[rd_i].b);
          chk("tw_addr", tw_addr, tbl[rd_i].tw);
          chk("raw_hazard", wr_i >= 4 * tbl[rd_i].st, 1);
          rd_cyc[rd_i] = cyc;
          rd_i++;
        end
      end
      if (wr_en) begin
        if (wr_i < rd_i) begin
          chk("wr_addr_a", wr_addr_a, tbl[wr_i].a);
          chk("wr_addr_b", wr_addr_b, tbl[wr_i].b);
          chk("wr_latency", cyc - rd_cyc[wr_i], 4);
          wr_i++;
        end else chk("wr_without_rd", wr_i, rd_i - 1);
      end
      if (done) begin
        chk("done_wr_count", wr_i, 12);
        fin = 1;
      end
      if (inj_start && !injected && rd_i == 2) begin
        start    = 1'b1;
        injected = 1;
      end
      if (abort && rd_i == 6) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("abort_outputs");
        return;
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    else begin
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_single", done, 0);
      chk("err_clean", err, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 0, 1, 0}; tbl[1]  = '{0, 2, 3, 0};
    tbl[2]  = '{0, 4, 5, 0}; tbl[3]  = '{0, 6, 7, 0};
    tbl[4]  = '{1, 0, 2, 0}; tbl[5]  = '{1, 1, 3, 2};
    tbl[6]  = '{1, 4, 6, 0}; tbl[7]  = '{1, 5, 7, 2};
    tbl[8]  = '{2, 0, 4, 0}; tbl[9]  = '{2, 1, 5, 1};
    tbl[10] = '{2, 2, 6, 2}; tbl[11] = '{2, 3, 7, 3};

    rst = 1'b1; start = 1'b0; inj = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle_outputs");

    run_fft(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_fft(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    run_fft(1'b0, 1'b1);
    @(negedge clk);
    chk_reset_vals("post_abort_idle");
    run_fft(1'b0, 1'b0);

    // Stray butterfly result while idle.
    @(negedge clk);
    inj = 1'b1;
    #1;
    chk("wr_en_idle", wr_en, 0);
    chk("err_before", err, 0);
    @(negedge clk);
    inj = 1'b0;
    chk("err_set", err, 1);
    @(negedge clk);
    chk("err_sticky", err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_cleared", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 Parameter LOG2N, default 8, log2 of FFT length N (N = 2^LOG2N, LOG2N >= 2).
REQ-002 Parameter RD_LAT, default 1, data-RAM read latency in cycles.
REQ-003 Parameter AW, default LOG2N, data-RAM address width; twiddle address width is LOG2N-1.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin an in-place FFT.
REQ-007 busy  out  1  high from the cycle after an accepted start until done.
REQ-008 done  out  1  one-cycle pulse when the last butterfly result is written.
REQ-009 stage  out  LOG2N bits  current stage index s.
REQ-010 rd_en  out  1  data-RAM read strobe for the operand pair.
REQ-011 rd_addr_a, rd_addr_b  out  AW each  operand addresses.
REQ-012 tw_addr  out  LOG2N-1 bits  twiddle ROM address, same cycle as rd_en.
REQ-013 bf_en  out  1  butterfly enable, rd_en delayed by RD_LAT cycles.
REQ-014 bf_finish  in  1  butterfly result-valid flag.
REQ-015 wr_en  out  1  write strobe, equal to bf_finish while busy.
REQ-016 wr_addr_a, wr_addr_b  out  AW each  write-back addresses for the current result.
REQ-017 err  out  1  sticky protocol-error flag.

Function
REQ-018 States: IDLE, ISSUE, DRAIN, NEXT, FIN; reset state is IDLE.
REQ-019 IDLE->ISSUE on start; start while not IDLE is ignored.
REQ-020 ISSUE: one butterfly per cycle, counter k = 0..N/2-1; rd_en=1 each cycle; k = N/2-1 -> DRAIN.
REQ-021 Addressing at stage s, half = 2^s: j = k mod half; rd_addr_a = ((k>>s)<<(s+1)) | j; rd_addr_b = rd_addr_a + half; tw_addr = j << (LOG2N-1-s).
REQ-022 DRAIN: no issue; leave when outstanding count = 0, preventing read-after-write hazards across stages.
REQ-023 Outstanding count increments on each rd_en, decrements on each bf_finish; both in one cycle leave it unchanged.
REQ-024 NEXT: if s = LOG2N-1 go to FIN, else s+1, k=0, go to ISSUE; NEXT lasts exactly one cycle.
REQ-025 FIN: done=1 for one cycle, then IDLE; busy low from IDLE.
REQ-026 Each issued (rd_addr_a, rd_addr_b) pair is pushed into an address FIFO; each bf_finish pops it and presents it on wr_addr_a/b in the same cycle as wr_en, combinationally from the FIFO head.
REQ-027 FIFO depth = 8, covering RD_LAT + 3-cycle butterfly latency + margin; the FIFO never overflows in correct operation.
REQ-028 bf_finish with empty FIFO or in IDLE sets err, and wr_en stays 0; err clears only on rst.
REQ-029 Total stages = LOG2N; butterflies per stage = N/2; counters wrap only through NEXT.

Reset
REQ-030 On rst: state IDLE, busy=0, done=0, rd_en=0, bf_en=0, wr_en=0, err=0, stage=0, all addresses 0, FIFO empty, outstanding=0.
REQ-031 rst mid-operation aborts immediately; RAM contents are undefined and no done is issued.

Structure
REQ-032 Shared package fft_pkg holds LOG2N, RD_LAT, butterfly latency constant BF_LAT=3, and state encodings.
REQ-033 One sub-module, fft_addr_fifo (synchronous FIFO, push/pop/empty/full, width 2*AW), instantiated once.
REQ-034 bf_en delay line is a shift register inside fft_ctrl.

Verification (LOG2N=3, RD_LAT=1, butterfly model latency 3)
REQ-035 Stage 0: start -> rd pairs (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0 on consecutive cycles.
REQ-036 Stages 1/2: pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2; then (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
REQ-037 rd_en at cycle t -> bf_en at t+1, wr_en at t+4 with wr_addr equal to the rd_addr from cycle t; no stage-1 rd_en before the last stage-0 wr_en.
REQ-038 Full run -> exactly 12 wr_en pulses, a single done pulse after the last, busy low the next cycle.
REQ-039 rst asserted during stage 1 -> all outputs at reset values the next cycle; a fresh start then completes normally.
REQ-040 bf_finish pulsed in IDLE -> err=1, wr_en=0; start during ISSUE -> ignored, address sequence unchanged.
